pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised, flow-controlled pipeline stage register: the next generation of the fixed ID/EX latch. It carries an arbitrary-width operand payload plus a separately handled control field across one stage boundary. It uses a valid/ready handshake with a two-entry skid buffer, so upstream ready is registered. It supports a synchronous flush for control hazards and keeps a saturating stall-cycle counter. One instance sits between each pair of pipeline stages (ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 128: payload width (operands, store data); held on bubbles.
- CTRL_W, 16: control width (write-enables, wb_select, alu_op, ...); forced to zero whenever out_valid=0.
- CNT_W, 16: width of the stall counter.
- sys_clk  in  1  clock; all state changes on posedge.
- sys_rst  in  1  one clock; reset is synchronous and active-low.
- flush  in  1  kill all held and incoming beats this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; registered (equals !skid_valid).
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  main entry holds a beat.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload.
- out_ctrl  out  CTRL_W  main entry control AND out_valid.
- occupancy  out  2  beats held, 0..2.
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1, out_ready=0.

## Operation
- Events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry; each entry has a valid bit, data and ctrl.
- States are named by occupancy: EMPTY(0), ONE(1), TWO(2).
- EMPTY: in_fire -> ONE, main<=in.
- ONE with in_fire & out_fire -> ONE, main<=in.
- ONE with in_fire & !out_ready -> TWO, skid<=in, main unchanged.
- ONE with !in_fire & out_fire -> EMPTY.
- ONE with neither event -> hold.
- TWO: in_ready=0, so no in_fire. out_fire -> ONE, main<=skid. Otherwise hold.
- Beats leave in arrival order. No beat is dropped or duplicated except on flush.
- flush has highest priority. Next state is EMPTY with both valid bits cleared. A beat accepted in the flush cycle is discarded. A downstream out_fire in the flush cycle still completes, because out_* are valid that cycle.
- out_ctrl is zero whenever out_valid=0, so bubbles never assert side-effects. out_data holds its last value on bubbles.
- stall_cycles increments by 1 each cycle where out_valid & !out_ready, and saturates at 2^CNT_W-1. It is cleared only by reset; flush does not clear it.

## Timing
- Reset (sys_rst=0 at posedge): out_valid=0, out_data=0, out_ctrl=0, in_ready=1, occupancy=0, stall_cycles=0; skid contents zeroed. Reset overrides flush and all handshakes.
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle) when the stage was EMPTY or ONE-draining.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready falls the cycle after the stage enters TWO and rises the cycle after a TWO->ONE drain. It never depends combinationally on out_ready or flush.
- occupancy, out_valid and in_ready are all registered; out_ctrl has one AND gate after the register.
- Reset asserted mid-transfer discards all held beats identically to flush and also clears the counter.

## Test plan
- Reset then idle: drive sys_rst=0 for 2 cycles -> all outputs 0, in_ready=1; after release with in_valid=0 nothing changes.
- Streaming: in_data=1..8 on consecutive cycles, out_ready=1 -> out_data=1..8 one cycle later, occupancy stays 1, stall_cycles=0.
- Backpressure: send A, B, C with out_ready=0 from cycle 1. Expected: occupancy 1 then 2; in_ready=0 after B; C held upstream; stall_cycles increments each stalled cycle. Release out_ready -> A, B, C in order, no loss.
- Flush while TWO with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1, flushed input beat never appears.
- Bubble control: out_ready=1, in_valid toggling with in_ctrl=16'hFFFF -> out_ctrl=16'hFFFF only on cycles with out_valid=1, 16'h0000 otherwise.
- Counter saturation with CNT_W=3: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cycles reaches 7 and stays at 7.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with a two-entry skid buffer.
// Ports: sys_clk, sys_rst (sync, active-low), flush, in_* / out_* valid-ready, occupancy, stall_cycles.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    stall_d     = stall_q;

    if (flush) begin
      // Payload registers are left alone so a killed beat never
      // reaches out_data, even as a bubble value.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (out_valid_q && !out_ready && stall_q != CNT_MAX) begin
      stall_d = stall_q + 1'b1;
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = main_data_q;
  // Bubbles must never carry side-effect enables downstream.
  assign out_ctrl     = main_ctrl_q & {CTRL_W{out_valid_q}};
  assign occupancy    = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: table vectors plus hand sequences,
// with a beat queue as the reference for order, occupancy and stalls.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cycles;

  pipe_stage_skid #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ctrl    (out_ctrl),
    .occupancy   (occupancy),
    .stall_cycles(stall_cycles)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic [1:0]    occ;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  int    exp_stall = 0;
  vec_t  tbl[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic fl, input logic iv, input logic [DW-1:0] d,
                             input logic [CW-1:0] c, input logic ordy, input logic [1:0] occ);
    vec_t r;
    r.fl = fl; r.iv = iv; r.d = d; r.c = c; r.ordy = ordy; r.occ = occ;
    return r;
  endfunction

  // One cycle: drive at negedge, check the registered outputs against
  // the queue model, then advance the model by that cycle's events.
  task automatic step(input logic fl, input logic iv, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy);
    logic  m_ov, m_ir, m_of, m_if;
    beat_t b;
    @(negedge sys_clk);
    flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    #1;
    m_ov = (q.size() > 0);
    m_ir = (q.size() != 2);
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("in_ready", 64'(in_ready), 64'(m_ir));
    chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    if (m_ov) begin
      chk("out_data", 64'(out_data), 64'(q[0].d));
      chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
    end else begin
      chk("bubble_ctrl", 64'(out_ctrl), 64'h0);
    end
    m_of = m_ov & ordy;
    m_if = iv & m_ir;
    if (m_ov && !ordy && exp_stall < (1 << NW) - 1) exp_stall++;
    if (m_of) void'(q.pop_front());
    if (fl) begin
      q.delete();
    end else if (m_if) begin
      b.d = d; b.c = c;
      q.push_back(b);
    end
  endtask

  initial begin
    // Streaming 1..8
    for (int i = 0; i < 8; i++)
      tbl[i] = v(0, 1, DW'(i + 1), CW'(16'h0100 + i), 1, (i == 0) ? 2'd0 : 2'd1);
    tbl[8]  = v(0, 0, 0, 0, 1, 1);
    tbl[9]  = v(0, 0, 0, 0, 0, 0);
    // Backpressure A, B, C
    tbl[10] = v(0, 1, 32'hA, 16'h0A0A, 0, 0);
    tbl[11] = v(0, 1, 32'hB, 16'h0B0B, 0, 1);
    tbl[12] = v(0, 1, 32'hC, 16'h0C0C, 0, 2);
    tbl[13] = v(0, 1, 32'hC, 16'h0C0C, 0, 2);
    tbl[14] = v(0, 1, 32'hC, 16'h0C0C, 1, 2);
    tbl[15] = v(0, 1, 32'hC, 16'h0C0C, 1, 1);
    tbl[16] = v(0, 0, 0, 0, 1, 1);
    tbl[17] = v(0, 0, 0, 0, 1, 0);
    // Flush while TWO with an incoming beat
    tbl[18] = v(0, 1, 32'h11, 16'h1111, 0, 0);
    tbl[19] = v(0, 1, 32'h22, 16'h2222, 0, 1);
    tbl[20] = v(1, 1, 32'h33, 16'h3333, 0, 2);
    tbl[21] = v(0, 0, 0, 0, 1, 0);
    // Flush coinciding with an output transfer
    tbl[22] = v(0, 1, 32'h44, 16'h4444, 1, 0);
    tbl[23] = v(1, 1, 32'h55, 16'h5555, 1, 1);
    tbl[24] = v(0, 0, 0, 0, 1, 0);
    // Bubble control with all-ones ctrl
    tbl[25] = v(0, 1, 32'h61, 16'hFFFF, 1, 0);
    tbl[26] = v(0, 0, 32'h61, 16'hFFFF, 1, 1);
    tbl[27] = v(0, 1, 32'h62, 16'hFFFF, 1, 0);
    tbl[28] = v(0, 0, 32'h62, 16'hFFFF, 1, 1);
    tbl[29] = v(0, 1, 32'h63, 16'hFFFF, 1, 0);
    tbl[30] = v(0, 0, 32'h63, 16'hFFFF, 1, 1);
    tbl[31] = v(0, 0, 0, 0, 1, 0);

    // Reset held for two edges, with flush and traffic asserted.
    @(negedge sys_clk);
    sys_rst = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    chk("rst_stall", 64'(stall_cycles), 64'h0);
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
      chk($sformatf("tbl_occ[%0d]", i), 64'(occupancy), 64'(tbl[i].occ));
    end
    chk("stall_after_tbl", 64'(exp_stall), 64'd5);

    // Reset mid-transfer with two beats held.
    step(0, 1, 32'h71, 16'h7171, 0);
    step(0, 1, 32'h72, 16'h7272, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    chk("pre_rst_occ", 64'(occupancy), 64'h2);
    @(negedge sys_clk);
    sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("midrst_occ", 64'(occupancy), 64'h0);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_ready", 64'(in_ready), 64'h1);
    chk("midrst_stall", 64'(stall_cycles), 64'h0);
    chk("midrst_data", 64'(out_data), 64'h0);
    q.delete();
    exp_stall = 0;

    // Stall counter saturation at 2^3-1.
    step(0, 1, 32'h81, 16'h00F0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("stall_saturated", 64'(stall_cycles), 64'd7);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("stall_held", 64'(stall_cycles), 64'd7);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
